// File: rtl/act_write_packer_pkg.sv
// Shared FSM encoding, bank indices and slot-width helper for the activation write packer.
package act_write_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bank index is {row[0], col[0]} of the 2x2 block.
    localparam logic [1:0] BANK_EVEN_EVEN = 2'd0;
    localparam logic [1:0] BANK_EVEN_ODD  = 2'd1;
    localparam logic [1:0] BANK_ODD_EVEN  = 2'd2;
    localparam logic [1:0] BANK_ODD_ODD   = 2'd3;

    localparam int DEF_SLOT_W = 4 * 16;

    function automatic int slot_width(input int act_per_addr, input int bw_per_act);
        return act_per_addr * bw_per_act;
    endfunction

endpackage

// File: rtl/act_write_addr_gen.sv
// Channel/column/row traversal counters with bank select, incremental SRAM address and last-quad flag.
module act_write_addr_gen #(
    parameter int CH_NUM  = 24,
    parameter int ADDR_BW = 10,
    parameter int DIM_BW  = 6,
    parameter int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               advance_i,
    input  logic [DIM_BW-1:0]  blk_w_i,
    input  logic [DIM_BW-1:0]  blk_h_i,
    output logic [CH_W-1:0]    ch_o,
    output logic [1:0]         bank_o,
    output logic [ADDR_BW-1:0] addr_o,
    output logic               last_o
);

    logic [CH_W-1:0]    ch_q, ch_d;
    logic [DIM_BW-1:0]  col_q, col_d;
    logic [DIM_BW-1:0]  row_q, row_d;
    logic [ADDR_BW-1:0] row_base_q, row_base_d;
    logic [ADDR_BW-1:0] half_w;
    logic               ch_end;
    logic               col_end;

    // Words per pair of block rows; row_base steps by this after each odd row.
    assign half_w  = ADDR_BW'(({1'b0, blk_w_i} + (DIM_BW+1)'(1)) >> 1);
    assign ch_end  = (ch_q == CH_W'(CH_NUM - 1));
    assign col_end = (col_q == blk_w_i - DIM_BW'(1));
    assign last_o  = ch_end && col_end && (row_q == blk_h_i - DIM_BW'(1));
    assign ch_o    = ch_q;
    assign bank_o  = {row_q[0], col_q[0]};
    assign addr_o  = row_base_q + ADDR_BW'(col_q >> 1);

    always_comb begin
        ch_d       = ch_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        if (clear_i || (advance_i && last_o)) begin
            ch_d       = '0;
            col_d      = '0;
            row_d      = '0;
            row_base_d = '0;
        end else if (advance_i) begin
            if (!ch_end) begin
                ch_d = ch_q + CH_W'(1);
            end else begin
                ch_d = '0;
                if (!col_end) begin
                    col_d = col_q + DIM_BW'(1);
                end else begin
                    col_d = '0;
                    row_d = row_q + DIM_BW'(1);
                    if (row_q[0]) begin
                        row_base_d = row_base_q + half_w;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
        end else begin
            ch_q       <= ch_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
        end
    end

endmodule

// File: rtl/act_write_packer.sv
// Packs 2x2 activation quads into banked SRAM writes, one channel slot per write.
// Optional ACT_WRITE_PACKER_RELU_EN clamps negative activations to zero before packing.
module act_write_packer
    import act_write_packer_pkg::*;
#(
    parameter int CH_NUM       = 24,
    parameter int ACT_PER_ADDR = 4,
    parameter int BW_PER_ACT   = 16,
    parameter int ADDR_BW      = 10,
    parameter int DIM_BW       = 6
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             start,
    input  logic                                             dst_sel,
    input  logic [DIM_BW-1:0]                                blk_w,
    input  logic [DIM_BW-1:0]                                blk_h,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic signed [BW_PER_ACT-1:0]                     act_0,
    input  logic signed [BW_PER_ACT-1:0]                     act_1,
    input  logic signed [BW_PER_ACT-1:0]                     act_2,
    input  logic signed [BW_PER_ACT-1:0]                     act_3,
    output logic [3:0]                                       sram_wen_a,
    output logic [3:0]                                       sram_wen_b,
    output logic [ADDR_BW-1:0]                               sram_waddr,
    output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT/8-1:0]      sram_wbytemask,
    output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]        sram_wdata,
    output logic                                             busy,
    output logic                                             done
);

    localparam int SLOT_W     = slot_width(ACT_PER_ADDR, BW_PER_ACT);
    localparam int DATA_W     = CH_NUM * SLOT_W;
    localparam int MASK_W     = DATA_W / 8;
    localparam int SLOT_BYTES = SLOT_W / 8;
    localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    state_e              state_q;
    logic                dst_q, busy_q, done_q;
    logic [DIM_BW-1:0]   blk_w_q, blk_h_q;
    logic                accept, start_ok, last;
    logic [CH_W-1:0]     ch;
    logic [1:0]          bank;
    logic [ADDR_BW-1:0]  addr;
    logic [BW_PER_ACT-1:0] act0_p, act1_p, act2_p, act3_p;
    logic [SLOT_W-1:0]   slot;
    int                  shift_ch;

    logic [3:0]          wen_a_q, wen_a_d, wen_b_q, wen_b_d;
    logic [ADDR_BW-1:0]  waddr_q, waddr_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    assign accept   = busy_q && in_valid;
    assign start_ok = (state_q == ST_IDLE) && start && (blk_w != '0) && (blk_h != '0);

`ifdef ACT_WRITE_PACKER_RELU_EN
    assign act0_p = act_0[BW_PER_ACT-1] ? '0 : act_0;
    assign act1_p = act_1[BW_PER_ACT-1] ? '0 : act_1;
    assign act2_p = act_2[BW_PER_ACT-1] ? '0 : act_2;
    assign act3_p = act_3[BW_PER_ACT-1] ? '0 : act_3;
`else
    assign act0_p = act_0;
    assign act1_p = act_1;
    assign act2_p = act_2;
    assign act3_p = act_3;
`endif

    assign slot = {act0_p, act1_p, act2_p, act3_p};

    act_write_addr_gen #(
        .CH_NUM  (CH_NUM),
        .ADDR_BW (ADDR_BW),
        .DIM_BW  (DIM_BW),
        .CH_W    (CH_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (start_ok),
        .advance_i (accept),
        .blk_w_i   (blk_w_q),
        .blk_h_i   (blk_h_q),
        .ch_o      (ch),
        .bank_o    (bank),
        .addr_o    (addr),
        .last_o    (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dst_q   <= 1'b0;
            blk_w_q <= '0;
            blk_h_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start_ok) begin
                    state_q <= ST_RUN;
                    dst_q   <= dst_sel;
                    blk_w_q <= blk_w;
                    blk_h_q <= blk_h;
                    busy_q  <= 1'b1;
                end
                ST_RUN: if (accept && last) begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Channel 0 occupies the most significant slot, so shift up by the slots below it.
    always_comb begin
        shift_ch = CH_NUM - 1 - int'(ch);
        wen_a_d  = 4'hF;
        wen_b_d  = 4'hF;
        waddr_d  = '0;
        wdata_d  = '0;
        mask_d   = '1;
        if (accept) begin
            if (dst_q) wen_b_d = ~(4'b0001 << bank);
            else       wen_a_d = ~(4'b0001 << bank);
            waddr_d = addr;
            wdata_d = DATA_W'(slot) << (shift_ch * SLOT_W);
            mask_d  = ~(MASK_W'({SLOT_BYTES{1'b1}}) << (shift_ch * SLOT_BYTES));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_a_q <= 4'hF;
            wen_b_q <= 4'hF;
            waddr_q <= '0;
            mask_q  <= '1;
            wdata_q <= '0;
        end else begin
            wen_a_q <= wen_a_d;
            wen_b_q <= wen_b_d;
            waddr_q <= waddr_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
        end
    end

    assign sram_wen_a     = wen_a_q;
    assign sram_wen_b     = wen_b_q;
    assign sram_waddr     = waddr_q;
    assign sram_wbytemask = mask_q;
    assign sram_wdata     = wdata_q;
    assign in_ready       = busy_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_act_write_packer.sv
// Directed + randomized bench for act_write_packer against a queue-based reference of the write stream.
module tb_act_write_packer;

    localparam int CH_NUM       = 24;
    localparam int ACT_PER_ADDR = 4;
    localparam int BW_PER_ACT   = 16;
    localparam int ADDR_BW      = 10;
    localparam int DIM_BW       = 6;
    localparam int SLOT_W       = ACT_PER_ADDR * BW_PER_ACT;
    localparam int DATA_W       = CH_NUM * SLOT_W;
    localparam int MASK_W       = DATA_W / 8;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       start = 1'b0;
    logic                       dst_sel = 1'b0;
    logic [DIM_BW-1:0]          blk_w = '0;
    logic [DIM_BW-1:0]          blk_h = '0;
    logic                       in_valid = 1'b0;
    logic                       in_ready;
    logic signed [BW_PER_ACT-1:0] act_0 = '0, act_1 = '0, act_2 = '0, act_3 = '0;
    logic [3:0]                 sram_wen_a, sram_wen_b;
    logic [ADDR_BW-1:0]         sram_waddr;
    logic [MASK_W-1:0]          sram_wbytemask;
    logic [DATA_W-1:0]          sram_wdata;
    logic                       busy, done;

    act_write_packer #(
        .CH_NUM(CH_NUM), .ACT_PER_ADDR(ACT_PER_ADDR), .BW_PER_ACT(BW_PER_ACT),
        .ADDR_BW(ADDR_BW), .DIM_BW(DIM_BW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dst_sel(dst_sel),
        .blk_w(blk_w), .blk_h(blk_h), .in_valid(in_valid), .in_ready(in_ready),
        .act_0(act_0), .act_1(act_1), .act_2(act_2), .act_3(act_3),
        .sram_wen_a(sram_wen_a), .sram_wen_b(sram_wen_b), .sram_waddr(sram_waddr),
        .sram_wbytemask(sram_wbytemask), .sram_wdata(sram_wdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bank;
        int addr;
        int ch;
    } quad_t;

    quad_t              expQ[$];
    int                 phase;
    bit                 mapDst;
    logic [3:0]         expWenA, expWenB;
    logic [ADDR_BW-1:0] expAddr;
    logic [DATA_W-1:0]  expData;
    logic [MASK_W-1:0]  expMask;
    logic               expBusy, expDone;
    int                 testsRun, testsFailed, obsWrites, obsBase;

    function automatic logic [15:0] relu(input logic [15:0] a);
`ifdef ACT_WRITE_PACKER_RELU_EN
        return a[15] ? 16'h0000 : a;
`else
        return a;
`endif
    endfunction

    function automatic int firstDiffSlot(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        for (int s = 0; s < CH_NUM; s++)
            if (a[DATA_W-1-s*SLOT_W -: SLOT_W] !== b[DATA_W-1-s*SLOT_W -: SLOT_W]) return s;
        return 0;
    endfunction

    task automatic setIdleExp();
        expWenA = 4'hF;
        expWenB = 4'hF;
        expAddr = '0;
        expData = '0;
        expMask = '1;
    endtask

    task automatic buildMap(input bit dsel, input int bw, input int bh);
        quad_t q;
        expQ.delete();
        mapDst = dsel;
        for (int r = 0; r < bh; r++)
            for (int c = 0; c < bw; c++)
                for (int k = 0; k < CH_NUM; k++) begin
                    q.bank = (r % 2) * 2 + (c % 2);
                    q.addr = (r / 2) * ((bw + 1) / 2) + c / 2;
                    q.ch   = k;
                    expQ.push_back(q);
                end
    endtask

    task automatic checkOutput(input string tag);
        int s;
        if (sram_wen_a != 4'hF || sram_wen_b != 4'hF) obsWrites++;
        testsRun++;
        assert (sram_wen_a === expWenA) else begin
            testsFailed++; $error("FAIL %s wen_a got %h want %h", tag, sram_wen_a, expWenA);
        end
        testsRun++;
        assert (sram_wen_b === expWenB) else begin
            testsFailed++; $error("FAIL %s wen_b got %h want %h", tag, sram_wen_b, expWenB);
        end
        testsRun++;
        assert (sram_waddr === expAddr) else begin
            testsFailed++; $error("FAIL %s waddr got %0d want %0d", tag, sram_waddr, expAddr);
        end
        testsRun++;
        assert (sram_wdata === expData) else begin
            testsFailed++;
            s = firstDiffSlot(sram_wdata, expData);
            $error("FAIL %s wdata slot %0d got %h want %h", tag, s,
                   sram_wdata[DATA_W-1-s*SLOT_W -: SLOT_W], expData[DATA_W-1-s*SLOT_W -: SLOT_W]);
        end
        testsRun++;
        assert (sram_wbytemask === expMask) else begin
            testsFailed++; $error("FAIL %s bytemask got %h want %h", tag, sram_wbytemask, expMask);
        end
        testsRun++;
        assert (busy === expBusy && in_ready === expBusy) else begin
            testsFailed++; $error("FAIL %s busy/in_ready got %b/%b want %b", tag, busy, in_ready, expBusy);
        end
        testsRun++;
        assert (done === expDone) else begin
            testsFailed++; $error("FAIL %s done got %b want %b", tag, done, expDone);
        end
    endtask

    // Check what the previous edge produced, then drive this cycle and predict the next edge.
    task automatic applyStimulus(input bit st, input bit dsel, input int bw, input int bh, input bit vld,
                                 input logic [15:0] a0, input logic [15:0] a1,
                                 input logic [15:0] a2, input logic [15:0] a3, input string tag);
        quad_t q;
        @(negedge clk);
        checkOutput(tag);
        start    = st;
        dst_sel  = dsel;
        blk_w    = bw[DIM_BW-1:0];
        blk_h    = bh[DIM_BW-1:0];
        in_valid = vld;
        act_0    = a0;
        act_1    = a1;
        act_2    = a2;
        act_3    = a3;
        setIdleExp();
        case (phase)
            0: if (st && bw != 0 && bh != 0) begin
                buildMap(dsel, bw, bh);
                phase = 1;
            end
            1: if (vld) begin
                q = expQ.pop_front();
                expData[DATA_W-1-q.ch*SLOT_W -: SLOT_W] = {relu(a0), relu(a1), relu(a2), relu(a3)};
                expMask[MASK_W-1-q.ch*8 -: 8] = 8'h00;
                if (mapDst) expWenB[q.bank] = 1'b0;
                else        expWenA[q.bank] = 1'b0;
                expAddr = ADDR_BW'(q.addr);
                if (expQ.size() == 0) phase = 2;
            end
            default: phase = 0;
        endcase
        expBusy = (phase == 1);
        expDone = (phase == 2);
    endtask

    task automatic finishMap(input bit gappy, input bit fixedFirst, input string tag);
        int budget;
        bit vld, st, first;
        first  = fixedFirst;
        budget = 0;
        while (phase != 0 && budget < 5000) begin
            vld = gappy ? ($urandom_range(0, 2) != 0) : 1'b1;
            st  = gappy ? ($urandom_range(0, 9) == 0) : 1'b0;
            if (first && vld) begin
                applyStimulus(st, ~mapDst, 1, 1, vld, 16'h0001, 16'h0002, 16'h0003, 16'h0004, tag);
                first = 1'b0;
            end else begin
                applyStimulus(st, ~mapDst, 1, 1, vld, 16'($urandom), 16'($urandom),
                              16'($urandom), 16'($urandom), tag);
            end
            budget++;
        end
        if (phase != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s timeout phase got %0d want 0", tag, phase);
        end
    endtask

    task automatic runMap(input bit dsel, input int bw, input int bh, input bit gappy,
                          input bit fixedFirst, input string tag);
        applyStimulus(1'b1, dsel, bw, bh, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, tag);
        finishMap(gappy, fixedFirst, tag);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        obsWrites   = 0;
        phase       = 0;
        mapDst      = 1'b0;
        setIdleExp();
        expBusy = 1'b0;
        expDone = 1'b0;

        applyStimulus(0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, "reset");
        rst_n = 1'b1;

        applyStimulus(1, 0, 0, 2, 1, 16'h0, 16'h0, 16'h0, 16'h0, "start_w0");
        applyStimulus(1, 0, 2, 0, 1, 16'h0, 16'h0, 16'h0, 16'h0, "start_h0");
        applyStimulus(0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, "after_bad_start");

        obsBase = obsWrites;
        runMap(0, 2, 2, 0, 1, "mapA");
        applyStimulus(0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, "mapA_end");
        testsRun++;
        assert (obsWrites - obsBase === 96) else begin
            testsFailed++; $error("FAIL mapA_count got %0d want 96", obsWrites - obsBase);
        end

        runMap(1, 3, 4, 1, 0, "mapC");
        applyStimulus(0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, "mapC_end");

        obsBase = obsWrites;
        applyStimulus(1, 0, 1, 1, 0, 16'h0, 16'h0, 16'h0, 16'h0, "gap_start");
        applyStimulus(0, 0, 1, 1, 1, 16'hFFFB, 16'h7FFF, 16'h8000, 16'h0005, "gap_v1");
        applyStimulus(1, 1, 2, 2, 0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, "gap_v0");
        applyStimulus(0, 0, 1, 1, 1, 16'hFFFB, 16'h0006, 16'h0007, 16'h0008, "gap_v1b");
        applyStimulus(0, 0, 1, 1, 0, 16'h0, 16'h0, 16'h0, 16'h0, "gap_idle0");
        applyStimulus(0, 0, 1, 1, 0, 16'h0, 16'h0, 16'h0, 16'h0, "gap_idle1");
        testsRun++;
        assert (obsWrites - obsBase === 2) else begin
            testsFailed++; $error("FAIL gap_count got %0d want 2", obsWrites - obsBase);
        end
        finishMap(0, 0, "gap_rest");
        applyStimulus(0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, "gap_end");

        applyStimulus(1, 1, 2, 2, 0, 16'h0, 16'h0, 16'h0, 16'h0, "rst_start");
        for (int i = 0; i < 10; i++)
            applyStimulus(0, 0, 1, 1, 1, 16'($urandom), 16'($urandom), 16'($urandom),
                          16'($urandom), "rst_accept");
        #2 rst_n = 1'b0;
        #1;
        phase = 0;
        expQ.delete();
        setIdleExp();
        expBusy = 1'b0;
        expDone = 1'b0;
        checkOutput("rst_async");
        applyStimulus(0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, "rst_hold");
        rst_n = 1'b1;
        runMap(0, 2, 2, 0, 0, "restart");
        applyStimulus(0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, "restart_end");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
